// File: rtl/elem_dispatch_if.sv
// elem_dispatch_if: proc command bus plus the per-element parameter fan-out.
// The master modport is the processor side; the slave modport is the dispatch side.
interface elem_dispatch_if #(
    parameter int NELEM         = 4,
    parameter int SEL_WIDTH     = 2,
    parameter int ENV_ADDRWIDTH = 12,
    parameter int PHASE_WIDTH   = 17,
    parameter int FREQ_WIDTH    = 9,
    parameter int AMP_WIDTH     = 16
);
    localparam int CFG_WIDTH = SEL_WIDTH + 2;
    logic                             cstrobe;
    logic [CFG_WIDTH-1:0]             cfg;
    logic [2*ENV_ADDRWIDTH-1:0]       env_word;
    logic [AMP_WIDTH-1:0]             amp;
    logic [FREQ_WIDTH-1:0]            freq;
    logic [PHASE_WIDTH-1:0]           phase;
    logic                             clear_err;
    logic [NELEM*ENV_ADDRWIDTH-1:0]   envstart;
    logic [NELEM*ENV_ADDRWIDTH-1:0]   envlength;
    logic [NELEM*AMP_WIDTH-1:0]       ampx;
    logic [NELEM*AMP_WIDTH-1:0]       ampy;
    logic [NELEM*FREQ_WIDTH-1:0]      freqaddr;
    logic [NELEM*PHASE_WIDTH-1:0]     pini;
    logic [NELEM*2-1:0]               mode;
    logic [NELEM-1:0]                 cmdstb;
    logic [NELEM-1:0]                 busy;
    logic [NELEM-1:0]                 overlap_err;
    logic                             badsel_err;
    modport master (
        output cstrobe, cfg, env_word, amp, freq, phase, clear_err,
        input  envstart, envlength, ampx, ampy, freqaddr, pini, mode,
               cmdstb, busy, overlap_err, badsel_err
    );
    modport slave (
        input  cstrobe, cfg, env_word, amp, freq, phase, clear_err,
        output envstart, envlength, ampx, ampy, freqaddr, pini, mode,
               cmdstb, busy, overlap_err, badsel_err
    );
endinterface

// File: rtl/elem_dispatch.sv
// elem_dispatch: decodes proc command strobes into registered per-element parameter sets,
// tracks envelope occupancy and raises sticky overlap / bad-select flags.
module elem_dispatch #(
    parameter int NELEM         = 4,
    parameter int SEL_WIDTH     = 2,
    parameter int ENV_ADDRWIDTH = 12,
    parameter int PHASE_WIDTH   = 17,
    parameter int FREQ_WIDTH    = 9,
    parameter int AMP_WIDTH     = 16
) (
    input logic            clk,
    input logic            reset,
    elem_dispatch_if.slave bus
);
    localparam int EW = ENV_ADDRWIDTH;
    logic [SEL_WIDTH-1:0]         sel;
    logic [NELEM-1:0]             hit;
    logic [NELEM-1:0]             ovl;
    logic                         bad;
    logic [NELEM-1:0][EW-1:0]     cnt;
    assign sel      = bus.cfg[SEL_WIDTH-1:0];
    assign bus.ampy = '0;
    always_comb begin
        hit  = '0;
        ovl  = '0;
        bad  = bus.cstrobe && (int'(sel) >= NELEM);
        for (int e = 0; e < NELEM; e++) begin
            hit[e]      = bus.cstrobe && (sel == SEL_WIDTH'(e));
            ovl[e]      = hit[e] && (cnt[e] > EW'(1));
            bus.busy[e] = |cnt[e];
        end
    end
    // Set beats clear when both land in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.envstart    <= '0;
            bus.envlength   <= '0;
            bus.ampx        <= '0;
            bus.freqaddr    <= '0;
            bus.pini        <= '0;
            bus.mode        <= '0;
            bus.cmdstb      <= '0;
            bus.overlap_err <= '0;
            bus.badsel_err  <= 1'b0;
            cnt             <= '0;
        end else begin
            for (int e = 0; e < NELEM; e++) begin
                if (hit[e]) begin
                    bus.envstart[e*EW +: EW]                <= bus.env_word[EW-1:0];
                    bus.envlength[e*EW +: EW]               <= bus.env_word[2*EW-1:EW];
                    bus.ampx[e*AMP_WIDTH +: AMP_WIDTH]      <= bus.amp;
                    bus.freqaddr[e*FREQ_WIDTH +: FREQ_WIDTH] <= bus.freq;
                    bus.pini[e*PHASE_WIDTH +: PHASE_WIDTH]  <= bus.phase;
                    bus.mode[e*2 +: 2]                      <= bus.cfg[SEL_WIDTH+1:SEL_WIDTH];
                    cnt[e]                                  <= bus.env_word[2*EW-1:EW];
                end else if (cnt[e] != '0) begin
                    cnt[e] <= cnt[e] - EW'(1);
                end
            end
            bus.cmdstb      <= hit;
            bus.overlap_err <= (bus.clear_err ? '0 : bus.overlap_err) | ovl;
            bus.badsel_err  <= (bus.clear_err ? 1'b0 : bus.badsel_err) | bad;
        end
    end
endmodule

// File: doc/elem_dispatch.md
# elem_dispatch

Parametrised fan-out stage between one `proc` core and `NELEM` signal-generator elements (qdrv/rdrv/rdlo-class). It is the successor to the fixed three-way, `cfg[1:0]`-decoded dispatch. Each processor command strobe is decoded into a registered per-element parameter set plus a one-cycle `cmdstb`. The block also tracks per-element envelope occupancy and flags sticky overlap and bad-select errors for the register map.

## Interface
Parameters:
- `NELEM`, 4: number of destination elements, 1..16.
- `SEL_WIDTH`, 2: element-select field width; must satisfy 2**`SEL_WIDTH` >= `NELEM`.
- `ENV_ADDRWIDTH`, 12: envelope start and length width.
- `PHASE_WIDTH`, 17: initial phase width.
- `FREQ_WIDTH`, 9: frequency-table address width.
- `AMP_WIDTH`, 16: amplitude width.
- `CFG_WIDTH`, `SEL_WIDTH`+2 (derived localparam): processor cfg word width.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `cstrobe` in 1: command valid from `proc`.
- `cfg` in `CFG_WIDTH`: [`SEL_WIDTH`-1:0] element select; [`SEL_WIDTH`+1:`SEL_WIDTH`] mode.
- `env_word` in 2*`ENV_ADDRWIDTH`: low half is envstart, high half is envlength.
- `amp` in `AMP_WIDTH`, `freq` in `FREQ_WIDTH`, `phase` in `PHASE_WIDTH`: pulse parameters.
- `clear_err` in 1: clears all sticky error flags.
- `envstart` out `NELEM`*`ENV_ADDRWIDTH`, `envlength` out `NELEM`*`ENV_ADDRWIDTH`: per-element envelope start and length; element e occupies slice e.
- `ampx` out `NELEM`*`AMP_WIDTH`, `freqaddr` out `NELEM`*`FREQ_WIDTH`, `pini` out `NELEM`*`PHASE_WIDTH`, `mode` out `NELEM`*2: per-element amplitude, frequency address, initial phase and mode.
- `ampy` out `NELEM`*`AMP_WIDTH`: tied to 0.
- `cmdstb` out `NELEM`: one-cycle per-element strobe.
- `busy` out `NELEM`: element envelope in progress.
- `overlap_err` out `NELEM`: sticky; command issued before the prior envelope ended.
- `badsel_err` out 1: sticky; select field >= `NELEM`.

## Operation
- Decode: `sel` = `cfg`[`SEL_WIDTH`-1:0]. A dispatch to element e occurs when `cstrobe` is high and `sel`==e<`NELEM`.
- On dispatch to e, element e's envstart, envlength, ampx, freqaddr, pini and mode registers load from the inputs.
  - `cmdstb`[e] is 1 on the next cycle.
  - All other elements hold their fields, and their `cmdstb` is 0.
- Bad select: `cstrobe` high with `sel`>=`NELEM`.
  - No dispatch occurs and no field changes.
  - `badsel_err` is set.
- Occupancy: each element has an `ENV_ADDRWIDTH`-bit down-counter `cnt`[e].
  - On dispatch, `cnt`[e] loads envlength.
  - Otherwise `cnt`[e] decrements while nonzero.
  - `busy`[e] = (`cnt`[e]!=0).
  - envlength==0 leaves `busy` low.
- Overlap: a dispatch to e while `cnt`[e]>1 sets `overlap_err`[e].
  - The command is still dispatched and `cnt`[e] reloads (newest command wins).
  - `cnt`[e]==1 is the legal back-to-back case and is not an error.
- `clear_err` zeroes all sticky flags on the next edge. If a set condition and `clear_err` occur in the same cycle, the set wins.
- Width rules: fields are copied bit-exact, with no arithmetic on pulse parameters. The down-counter never wraps below 0.

## Timing
- Latency: input cycle t produces registered fields and `cmdstb` valid at t+1. Fields stay stable until that element's next dispatch.
- A dispatch at input cycle t with envlength L gives `busy`[e] high for cycles t+1..t+L inclusive.
- Error flags are visible at t+1 after the offending input cycle.
- `cstrobe` may be high on consecutive cycles, to the same or different elements. Each cycle is independent, with full throughput of 1 command/cycle.
- Reset, checked at the clock edge:
  - All field outputs, `cmdstb`, `cnt`, `busy`, `overlap_err` and `badsel_err` go to 0.
  - A `cstrobe` in the reset cycle is discarded.
  - Reset mid-envelope drops `busy` at the next cycle.

## Test plan
- Reset then single command. Inputs: NELEM=4, `cfg`=4'b10_01, env_word={12'd8,12'h010}, amp=16'h4000, freq=9'd5, phase=17'd100. Required at t+1:
  - `cmdstb`=4'b0010.
  - Element 1 fields: envstart=0x010, envlength=8, ampx=0x4000, freqaddr=5, pini=100, mode=2'b10.
  - `busy`[1] high for cycles t+1..t+8.
  - Other elements all 0.
- Back-to-back round-robin: `sel`=0,1,2,3 on 4 consecutive cycles -> `cmdstb` walks 0001,0010,0100,1000. Each element's fields match its own command; no errors.
- Overlap: command to element 2 with L=10 at t, then again with L=4 at t+3 -> `overlap_err`[2]=1 at t+4, `busy`[2] high through t+7. With the second command at t+10 instead, `overlap_err` stays 0.
- Bad select with NELEM=3, SEL_WIDTH=2: `sel`=3 -> `cmdstb`=0, fields unchanged, `badsel_err`=1. `clear_err` pulse then clears it; `clear_err` coincident with a new bad select leaves it at 1.
- Zero length: envlength=0 -> `cmdstb` pulses and `busy` stays 0. An immediate re-dispatch raises no overlap.
- Reset mid-envelope: reset asserted at t+3 of an L=20 pulse, with `cstrobe` also high -> `busy`, `cmdstb`, fields and flags all 0 at t+4, and the command in the reset cycle is not issued.
